// File: rtl/button_conditioner_pkg.sv
// Shared definitions for the pushbutton conditioner: hold FSM state encoding
// and counter-width helpers used to size the debounce and hold counters.
package button_conditioner_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      HELD   = 2'd1,
      REPEAT = 2'd2
   } hold_state_t;

   // Width needed to count 0..n-1, never narrower than one bit.
   function automatic int cnt_w(input int n);
      int w;
      w = $clog2(n);
      return (w < 1) ? 1 : w;
   endfunction

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/debounce_filter.sv
// Two-flop synchroniser followed by a stability counter. level_clean only
// takes a new value after sync2 has disagreed with it for DEBOUNCE_CYCLES
// consecutive cycles; any agreement in between restarts the count.
//
// Ports:
//   clk         system clock
//   reset       asynchronous, active-high reset
//   btn_raw     raw pin, asynchronous to clk
//   level_clean debounced level, same polarity as btn_raw (idles at NC)
module debounce_filter
   import button_conditioner_pkg::*;
#(
   parameter bit NC              = 1'b0,
   parameter int DEBOUNCE_CYCLES = 500000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level_clean
);

   localparam int             DW    = cnt_w(DEBOUNCE_CYCLES);
   localparam logic [DW-1:0]  DB_TC = DW'(DEBOUNCE_CYCLES - 1);

   logic          sync1;
   logic          sync2;
   logic [DW-1:0] db_cnt;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         sync1       <= NC;
         sync2       <= NC;
         level_clean <= NC;
         db_cnt      <= '0;
      end else begin
         sync1 <= btn_raw;
         sync2 <= sync1;
         if (sync2 == level_clean) begin
            db_cnt <= '0;
         end else if (db_cnt == DB_TC) begin
            level_clean <= sync2;
            db_cnt      <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
      end
   end

endmodule

// File: rtl/button_conditioner.sv
// Per-button front end: synchronise and debounce the raw pin, then track how
// long the button stays pressed to raise a long-press pulse and, while still
// held, periodic auto-repeat pulses.
//
// Ports:
//   clk          system clock
//   reset        asynchronous, active-high reset
//   btn_raw      raw pin, asynchronous to clk
//   level_clean  debounced level, same polarity as btn_raw
//   pressed      1 while the button is physically pressed
//   long_press   one-cycle pulse when the hold reaches HOLD_CYCLES
//   repeat_tick  one-cycle pulse every REPEAT_CYCLES after long_press
//
// state  | meaning
// IDLE   | button released, hold counter parked at 0
// HELD   | pressed, counting towards long_press
// REPEAT | long_press already issued, counting repeat periods
module button_conditioner
   import button_conditioner_pkg::*;
#(
   parameter bit NC              = 1'b0,
   parameter int DEBOUNCE_CYCLES = 500000,
   parameter int HOLD_CYCLES     = 50000000,
   parameter int REPEAT_CYCLES   = 10000000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic level_clean,
   output logic pressed,
   output logic long_press,
   output logic repeat_tick
);

   localparam int            HW      = cnt_w(max_int(HOLD_CYCLES, REPEAT_CYCLES));
   localparam logic [HW-1:0] HOLD_TC = HW'(HOLD_CYCLES - 1);
   localparam logic [HW-1:0] REP_TC  = HW'(REPEAT_CYCLES - 1);

   hold_state_t   state;
   hold_state_t   state_nxt;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_cnt_nxt;

   debounce_filter #(
      .NC              (NC),
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
   ) u_debounce (
      .clk         (clk),
      .reset       (reset),
      .btn_raw     (btn_raw),
      .level_clean (level_clean)
   );

   assign pressed = level_clean ^ NC;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state    <= IDLE;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         hold_cnt <= hold_cnt_nxt;
      end
   end

   // Release is tested before terminal count so a release landing on the
   // terminal cycle suppresses the pulse.
   always_comb begin
      state_nxt    = state;
      hold_cnt_nxt = hold_cnt;
      long_press   = 1'b0;
      repeat_tick  = 1'b0;
      case (state)
         IDLE: begin
            if (pressed) begin
               state_nxt    = HELD;
               hold_cnt_nxt = HW'(1);
            end else begin
               hold_cnt_nxt = '0;
            end
         end
         HELD: begin
            if (!pressed) begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end else if (hold_cnt == HOLD_TC) begin
               long_press   = 1'b1;
               state_nxt    = REPEAT;
               hold_cnt_nxt = '0;
            end else begin
               hold_cnt_nxt = hold_cnt + HW'(1);
            end
         end
         REPEAT: begin
            if (!pressed) begin
               state_nxt    = IDLE;
               hold_cnt_nxt = '0;
            end else if (hold_cnt == REP_TC) begin
               repeat_tick  = 1'b1;
               hold_cnt_nxt = '0;
            end else begin
               hold_cnt_nxt = hold_cnt + HW'(1);
            end
         end
         default: begin
            state_nxt    = IDLE;
            hold_cnt_nxt = '0;
         end
      endcase
   end

endmodule
